// File: rtl/id_stage_pipe.sv
// RV32I decode stage: register file, immediate generation and control decode,
// registered behind a one-entry valid/ready pipeline slot with write-back bypass.
module id_stage_pipe #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int BYPASS    = 1,
  parameter int ALU_SEL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [XLEN-1:0]      in_pc,
  input  logic                 flush,
  input  logic                 wb_en,
  input  logic [4:0]           wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_rs1_data,
  output logic [XLEN-1:0]      out_rs2_data,
  output logic [XLEN-1:0]      out_imm,
  output logic [4:0]           out_rd,
  output logic [ALU_SEL_W-1:0] out_alu_sel,
  output logic [1:0]           out_a_sel,
  output logic                 out_b_sel,
  output logic                 out_reg_write,
  output logic                 out_mem_read,
  output logic                 out_mem_write,
  output logic [2:0]           out_funct3,
  output logic                 out_branch,
  output logic                 out_jump,
  output logic                 out_system,
  output logic                 out_illegal
);

  localparam int AW = (NREGS == 16) ? 4 : 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [ALU_SEL_W-1:0] ALU_ADD  = ALU_SEL_W'(0);
  localparam logic [ALU_SEL_W-1:0] ALU_SUB  = ALU_SEL_W'(1);
  localparam logic [ALU_SEL_W-1:0] ALU_AND  = ALU_SEL_W'(2);
  localparam logic [ALU_SEL_W-1:0] ALU_OR   = ALU_SEL_W'(3);
  localparam logic [ALU_SEL_W-1:0] ALU_XOR  = ALU_SEL_W'(4);
  localparam logic [ALU_SEL_W-1:0] ALU_SLT  = ALU_SEL_W'(5);
  localparam logic [ALU_SEL_W-1:0] ALU_SLTU = ALU_SEL_W'(6);
  localparam logic [ALU_SEL_W-1:0] ALU_SLL  = ALU_SEL_W'(7);
  localparam logic [ALU_SEL_W-1:0] ALU_SRL  = ALU_SEL_W'(8);
  localparam logic [ALU_SEL_W-1:0] ALU_SRA  = ALU_SEL_W'(9);

  logic [XLEN-1:0] rf [NREGS];
  logic [4:0] held_rs1, held_rs2;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd_f, rs1_f, rs2_f;
  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rd_f   = in_instr[11:7];
  assign rs1_f  = in_instr[19:15];
  assign rs2_f  = in_instr[24:20];

  logic wb_we, accept;
  assign wb_we    = wb_en && (wb_addr != 5'd0) && ((NREGS == 32) || !wb_addr[4]);
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  logic use_rs1, use_rs2, use_rd, ill;
  logic d_b_sel, d_rw, d_mr, d_mw, d_br, d_jmp, d_sys;
  logic [1:0] d_a_sel;
  logic [ALU_SEL_W-1:0] d_alu;
  logic [31:0] imm32;
  logic [XLEN-1:0] rs1_val, rs2_val;

  always_comb begin
    use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0; ill = 1'b0;
    d_b_sel = 1'b0; d_rw = 1'b0; d_mr = 1'b0; d_mw = 1'b0;
    d_br = 1'b0; d_jmp = 1'b0; d_sys = 1'b0;
    d_a_sel = 2'b00;
    d_alu = ALU_ADD;
    imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
    case (opcode)
      OPC_OPIMM: begin
        use_rs1 = 1'b1; use_rd = 1'b1; d_b_sel = 1'b1; d_rw = 1'b1;
        case (funct3)
          3'b000: d_alu = ALU_ADD;
          3'b010: d_alu = ALU_SLT;
          3'b011: d_alu = ALU_SLTU;
          3'b100: d_alu = ALU_XOR;
          3'b110: d_alu = ALU_OR;
          3'b111: d_alu = ALU_AND;
          3'b001: begin
            d_alu = ALU_SLL;
            imm32 = {27'd0, in_instr[24:20]};
            ill = (funct7 != 7'b0000000);
          end
          default: begin
            imm32 = {27'd0, in_instr[24:20]};
            d_alu = funct7[5] ? ALU_SRA : ALU_SRL;
            ill = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          end
        endcase
      end
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; d_rw = 1'b1;
        ill = ((funct7 != 7'b0000000) && (funct7 != 7'b0100000)) ||
              (funct7[5] && (funct3 != 3'b000) && (funct3 != 3'b101));
        case (funct3)
          3'b000:  d_alu = funct7[5] ? ALU_SUB : ALU_ADD;
          3'b001:  d_alu = ALU_SLL;
          3'b010:  d_alu = ALU_SLT;
          3'b011:  d_alu = ALU_SLTU;
          3'b100:  d_alu = ALU_XOR;
          3'b101:  d_alu = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  d_alu = ALU_OR;
          default: d_alu = ALU_AND;
        endcase
      end
      OPC_LUI, OPC_AUIPC: begin
        use_rd = 1'b1; d_rw = 1'b1; d_b_sel = 1'b1;
        d_a_sel = (opcode == OPC_LUI) ? 2'b10 : 2'b01;
        imm32 = {in_instr[31:12], 12'd0};
      end
      OPC_JAL: begin
        use_rd = 1'b1; d_rw = 1'b1; d_jmp = 1'b1; d_b_sel = 1'b1; d_a_sel = 2'b01;
        imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                 in_instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        use_rs1 = 1'b1; use_rd = 1'b1; d_rw = 1'b1; d_jmp = 1'b1; d_b_sel = 1'b1;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; d_br = 1'b1; d_alu = ALU_SUB;
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                 in_instr[11:8], 1'b0};
        ill = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        use_rs1 = 1'b1; use_rd = 1'b1; d_rw = 1'b1; d_mr = 1'b1; d_b_sel = 1'b1;
        ill = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; d_mw = 1'b1; d_b_sel = 1'b1;
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        ill = (funct3 > 3'b010);
      end
      OPC_FENCE: ;
      OPC_SYSTEM: d_sys = (in_instr == 32'h0000_0073) || (in_instr == 32'h0010_0073);
      default: ill = 1'b1;
    endcase
    if ((NREGS == 16) && ((use_rs1 && rs1_f[4]) || (use_rs2 && rs2_f[4]) || (use_rd && rd_f[4])))
      ill = 1'b1;
    if (ill) begin
      d_rw = 1'b0; d_mr = 1'b0; d_mw = 1'b0; d_br = 1'b0; d_jmp = 1'b0;
    end
  end

  // Operand read with optional same-cycle forwarding of the write-back port
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (use_rs1 && rs1_f != 5'd0)
      rs1_val = (BYPASS != 0 && wb_we && wb_addr == rs1_f) ? wb_data : rf[rs1_f[AW-1:0]];
    if (use_rs2 && rs2_f != 5'd0)
      rs2_val = (BYPASS != 0 && wb_we && wb_addr == rs2_f) ? wb_data : rf[rs2_f[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_we) begin
      rf[wb_addr[AW-1:0]] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0; out_pc <= '0; out_rs1_data <= '0; out_rs2_data <= '0;
      out_imm <= '0; out_rd <= '0; out_alu_sel <= '0; out_a_sel <= '0;
      out_b_sel <= 1'b0; out_reg_write <= 1'b0; out_mem_read <= 1'b0;
      out_mem_write <= 1'b0; out_funct3 <= '0; out_branch <= 1'b0;
      out_jump <= 1'b0; out_system <= 1'b0; out_illegal <= 1'b0;
      held_rs1 <= '0; held_rs2 <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      out_rs1_data  <= rs1_val;
      out_rs2_data  <= rs2_val;
      out_imm       <= XLEN'($signed(imm32));
      out_rd        <= use_rd ? rd_f : 5'd0;
      out_alu_sel   <= d_alu;
      out_a_sel     <= d_a_sel;
      out_b_sel     <= d_b_sel;
      out_reg_write <= d_rw;
      out_mem_read  <= d_mr;
      out_mem_write <= d_mw;
      out_funct3    <= funct3;
      out_branch    <= d_br;
      out_jump      <= d_jmp;
      out_system    <= d_sys;
      out_illegal   <= ill;
      held_rs1      <= use_rs1 ? rs1_f : 5'd0;
      held_rs2      <= use_rs2 ? rs2_f : 5'd0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      // A held bundle picks up late write-backs so it never issues stale operands
      if (out_valid && wb_we && wb_addr == held_rs1) out_rs1_data <= wb_data;
      if (out_valid && wb_we && wb_addr == held_rs2) out_rs2_data <= wb_data;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: default RV32I instance plus an RV32E instance.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush, wb_en, out_ready;
  logic [31:0] in_instr, in_pc, wb_data;
  logic [4:0]  wb_addr;
  logic        in_ready, out_valid, out_b_sel, out_reg_write, out_mem_read, out_mem_write;
  logic        out_branch, out_jump, out_system, out_illegal;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]  out_rd;
  logic [3:0]  out_alu_sel;
  logic [1:0]  out_a_sel;
  logic [2:0]  out_funct3;

  logic        e_in_valid;
  logic [31:0] e_in_instr;
  logic        e_in_ready, e_out_valid, e_out_b_sel, e_out_reg_write, e_out_mem_read;
  logic        e_out_mem_write, e_out_branch, e_out_jump, e_out_system, e_out_illegal;
  logic [31:0] e_out_pc, e_out_rs1_data, e_out_rs2_data, e_out_imm;
  logic [4:0]  e_out_rd;
  logic [3:0]  e_out_alu_sel;
  logic [1:0]  e_out_a_sel;
  logic [2:0]  e_out_funct3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_imm(out_imm), .out_rd(out_rd), .out_alu_sel(out_alu_sel), .out_a_sel(out_a_sel),
    .out_b_sel(out_b_sel), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_funct3(out_funct3), .out_branch(out_branch),
    .out_jump(out_jump), .out_system(out_system), .out_illegal(out_illegal)
  );

  id_stage_pipe #(.NREGS(16)) dut_e (
    .clk(clk), .rst_n(rst_n), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .in_instr(e_in_instr), .in_pc(in_pc), .flush(1'b0), .wb_en(1'b0),
    .wb_addr(5'd0), .wb_data(32'd0), .out_valid(e_out_valid), .out_ready(1'b1),
    .out_pc(e_out_pc), .out_rs1_data(e_out_rs1_data), .out_rs2_data(e_out_rs2_data),
    .out_imm(e_out_imm), .out_rd(e_out_rd), .out_alu_sel(e_out_alu_sel),
    .out_a_sel(e_out_a_sel), .out_b_sel(e_out_b_sel), .out_reg_write(e_out_reg_write),
    .out_mem_read(e_out_mem_read), .out_mem_write(e_out_mem_write),
    .out_funct3(e_out_funct3), .out_branch(e_out_branch), .out_jump(e_out_jump),
    .out_system(e_out_system), .out_illegal(e_out_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0; wb_data = '0; wb_addr = '0;
    e_in_valid = 1'b0; e_in_instr = '0;
    tick; tick;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_imm", out_imm, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // addi x1,x0,-5
    in_valid = 1'b1; in_instr = 32'hFFB0_0093; in_pc = 32'h100;
    tick;
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_imm", out_imm, 32'hFFFF_FFFB);
    chk("addi_alu", 32'(out_alu_sel), 32'd0);
    chk("addi_bsel", 32'(out_b_sel), 32'd1);
    chk("addi_rd", 32'(out_rd), 32'd1);
    chk("addi_rw", 32'(out_reg_write), 32'd1);
    chk("addi_pc", out_pc, 32'h100);

    // add x3,x2,x2 with write-back x2=0x1234 in the same cycle
    in_instr = 32'h0021_01B3; in_pc = 32'h104;
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h1234;
    tick;
    wb_en = 1'b0;
    chk("bypass_rs1", out_rs1_data, 32'h1234);
    chk("bypass_rs2", out_rs2_data, 32'h1234);
    chk("add_bsel", 32'(out_b_sel), 32'd0);

    // sub x6,x5,x0 then stall with a late write-back to x5
    in_instr = 32'h4002_8333; in_pc = 32'h108;
    tick;
    chk("sub_alu", 32'(out_alu_sel), 32'd1);
    chk("sub_rs1_old", out_rs1_data, 32'd0);
    out_ready = 1'b0; in_instr = 32'h0010_8493; in_pc = 32'h10C;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'd7;
    #1;
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    tick;
    wb_addr = 5'd0; wb_data = 32'hDEAD;
    chk("stall_rs1_refresh", out_rs1_data, 32'd7);
    chk("stall_rd", 32'(out_rd), 32'd6);
    tick;
    wb_en = 1'b0;
    tick;
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_rs2_x0", out_rs2_data, 32'd0);
    chk("stall_pc", out_pc, 32'h108);
    chk("stall_alu", 32'(out_alu_sel), 32'd1);
    chk("stall_in_ready2", 32'(in_ready), 32'd0);

    // add x7,x5,x2 reads registers written earlier
    out_ready = 1'b1; in_instr = 32'h0022_83B3; in_pc = 32'h110;
    tick;
    chk("rf_rs1_x5", out_rs1_data, 32'd7);
    chk("rf_rs2_x2", out_rs2_data, 32'h1234);
    chk("rf_rd", 32'(out_rd), 32'd7);

    // beq x1,x2,-8
    in_instr = 32'hFE20_8CE3; in_pc = 32'h114;
    tick;
    chk("beq_branch", 32'(out_branch), 32'd1);
    chk("beq_alu", 32'(out_alu_sel), 32'd1);
    chk("beq_imm", out_imm, 32'hFFFF_FFF8);
    chk("beq_rw", 32'(out_reg_write), 32'd0);
    chk("beq_rs2", out_rs2_data, 32'h1234);

    // flush with a held bundle and an incoming lui
    flush = 1'b1; out_ready = 1'b0; in_instr = 32'h1234_5537; in_pc = 32'h118;
    tick;
    chk("flush_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    tick;
    chk("flush_no_appear", 32'(out_valid), 32'd0);

    // lui x10,0x12345 accepted after flush
    in_valid = 1'b1; out_ready = 1'b1;
    tick;
    chk("lui_valid", 32'(out_valid), 32'd1);
    chk("lui_asel", 32'(out_a_sel), 32'd2);
    chk("lui_imm", out_imm, 32'h1234_5000);
    chk("lui_rd", 32'(out_rd), 32'd10);
    in_valid = 1'b0;
    tick;
    chk("drain_valid", 32'(out_valid), 32'd0);

    // jal x1,+8
    in_valid = 1'b1; in_instr = 32'h0080_00EF; in_pc = 32'h200;
    tick;
    chk("jal_jump", 32'(out_jump), 32'd1);
    chk("jal_asel", 32'(out_a_sel), 32'd1);
    chk("jal_imm", out_imm, 32'd8);
    chk("jal_pc", out_pc, 32'h200);

    // sw x2,12(x1)
    in_instr = 32'h0020_A623;
    tick;
    chk("sw_memw", 32'(out_mem_write), 32'd1);
    chk("sw_rw", 32'(out_reg_write), 32'd0);
    chk("sw_imm", out_imm, 32'd12);
    chk("sw_funct3", 32'(out_funct3), 32'd2);

    // srai x4,x1,3 and unknown opcode, with RV32E add x20,x1,x1 in parallel
    in_instr = 32'h4030_D213;
    e_in_valid = 1'b1; e_in_instr = 32'h0010_8A33;
    tick;
    chk("srai_alu", 32'(out_alu_sel), 32'd9);
    chk("srai_imm", out_imm, 32'd3);
    chk("e_x20_illegal", 32'(e_out_illegal), 32'd1);
    chk("e_x20_rw", 32'(e_out_reg_write), 32'd0);
    in_instr = 32'h0000_007F;
    e_in_instr = 32'h0010_81B3;
    tick;
    chk("op7f_illegal", 32'(out_illegal), 32'd1);
    chk("op7f_rw", 32'(out_reg_write), 32'd0);
    chk("op7f_valid", 32'(out_valid), 32'd1);
    chk("e_x3_illegal", 32'(e_out_illegal), 32'd0);
    chk("e_x3_rw", 32'(e_out_reg_write), 32'd1);

    // load with reserved funct3, then ecall
    in_instr = 32'h0000_B083;
    tick;
    chk("ld_illegal", 32'(out_illegal), 32'd1);
    chk("ld_memr", 32'(out_mem_read), 32'd0);
    in_instr = 32'h0000_0073;
    tick;
    chk("ecall_sys", 32'(out_system), 32'd1);
    chk("ecall_illegal", 32'(out_illegal), 32'd0);
    in_valid = 1'b0; e_in_valid = 1'b0;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
